// File: rtl/wts_timer_pkg.sv
// wts_timer_pkg: shared definitions for the wave-table timer array.
//   - tmr_state_e : per-timer FSM state encoding
//   - DEF_ADDR_W  : default trigger address width
//   - DEF_CNT_W   : default saturating event counter width
package wts_timer_pkg;

    typedef enum logic [1:0] {
        TMR_DISABLED = 2'd0,
        TMR_ARMED    = 2'd1,
        TMR_LOCKED   = 2'd2
    } tmr_state_e;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/wts_timer_unit.sv
// wts_timer_unit: one event timer (FSM, per-address flags, saturating
// counter, optional sticky overrun flag).
// Optional feature macro: WTS_TIMER_OVERRUN_EN (overrun tracking; when
// undefined, overrun is tied to 0).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   trigger    : one-cycle event pulse
//   address    : event address selecting the flag to set
//   enable     : level, 1 = timer enabled
//   oneshot    : level, 1 = lock after first accepted event
//   clear      : one-cycle pulse clearing flags/count/overrun and unlocking
//   status     : event flags
//   count      : accepted-event count (saturating)
//   overrun    : sticky overrun flag
//   state      : current FSM state (debug visibility)
module wts_timer_unit
    import wts_timer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic [ADDR_W-1:0]      address,
    input  logic                   enable,
    input  logic                   oneshot,
    input  logic                   clear,
    output logic [(2**ADDR_W)-1:0] status,
    output logic [CNT_W-1:0]       count,
    output logic                   overrun,
    output tmr_state_e             state
);

    localparam int STATUS_W = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tmr_state_e          state_q, state_d;
    logic [STATUS_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                accepted;

    // Clear acts before trigger evaluation, so a LOCKED timer being cleared
    // behaves as ARMED for a trigger arriving in the same cycle.
    always_comb begin
        accepted = trigger && ((state_q == TMR_ARMED) ||
                               ((state_q == TMR_LOCKED) && clear));
        flags_d  = clear ? '0 : flags_q;
        count_d  = clear ? '0 : count_q;
        if (accepted) begin
            flags_d[address] = 1'b1;
            if (count_d != CNT_MAX) begin
                count_d = count_d + 1'b1;
            end
        end

        state_d = state_q;
        case (state_q)
            TMR_DISABLED: begin
                if (enable) state_d = TMR_ARMED;
            end
            TMR_ARMED: begin
                if (!enable)                  state_d = TMR_DISABLED;
                else if (accepted && oneshot) state_d = TMR_LOCKED;
            end
            TMR_LOCKED: begin
                // oneshot is only re-evaluated once clear has unlocked the timer
                if (!enable)   state_d = TMR_DISABLED;
                else if (clear) state_d = (accepted && oneshot) ? TMR_LOCKED : TMR_ARMED;
            end
            default: state_d = TMR_DISABLED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TMR_DISABLED;
            flags_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            count_q <= count_d;
        end
    end

`ifdef WTS_TIMER_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Overrun: a trigger lost to the lock, or an event landing on a flag
    // that is still set. A same-cycle clear wipes the old flags first.
    always_comb begin
        overrun_d = clear ? 1'b0 : overrun_q;
        if (!clear && ((trigger && (state_q == TMR_LOCKED)) ||
                       (accepted && flags_q[address]))) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign status = flags_q;
    assign count  = count_q;
    assign state  = state_q;

endmodule

// File: rtl/wts_timer_array.sv
// wts_timer_array: NUM_TIMERS independent event timers sharing one
// active-low interrupt line.
// Optional feature macro: WTS_TIMER_OVERRUN_EN (per-timer overrun flags).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   timer_trigger     : per-timer event pulse
//   timer_address     : per-timer event address, slice [i*ADDR_W +: ADDR_W]
//   reg_timer_enable  : per-timer enable level
//   reg_timer_oneshot : per-timer one-shot lock level
//   reg_timer_clear   : per-timer clear pulse
//   timer_status      : per-timer flags, slice [i*STATUS_W +: STATUS_W]
//   timer_count       : per-timer counts, slice [i*CNT_W +: CNT_W]
//   timer_overrun     : per-timer overrun flags
//   nint              : active-low interrupt
module wts_timer_array
    import wts_timer_pkg::*;
#(
    parameter int NUM_TIMERS = 2,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_TIMERS-1:0]               timer_trigger,
    input  logic [NUM_TIMERS*ADDR_W-1:0]        timer_address,
    input  logic [NUM_TIMERS-1:0]               reg_timer_enable,
    input  logic [NUM_TIMERS-1:0]               reg_timer_oneshot,
    input  logic [NUM_TIMERS-1:0]               reg_timer_clear,
    output logic [NUM_TIMERS*(2**ADDR_W)-1:0]   timer_status,
    output logic [NUM_TIMERS*CNT_W-1:0]         timer_count,
    output logic [NUM_TIMERS-1:0]               timer_overrun,
    output logic                                nint
);

    localparam int STATUS_W = 2**ADDR_W;

    logic [NUM_TIMERS-1:0] timer_irq;
    // FSM state of every timer, kept for debug probes only
    tmr_state_e            timer_state_unused [NUM_TIMERS];

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
        wts_timer_unit #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_unit (
            .clk     (clk),
            .reset   (reset),
            .trigger (timer_trigger[i]),
            .address (timer_address[i*ADDR_W +: ADDR_W]),
            .enable  (reg_timer_enable[i]),
            .oneshot (reg_timer_oneshot[i]),
            .clear   (reg_timer_clear[i]),
            .status  (timer_status[i*STATUS_W +: STATUS_W]),
            .count   (timer_count[i*CNT_W +: CNT_W]),
            .overrun (timer_overrun[i]),
            .state   (timer_state_unused[i])
        );

        // Disabled timers keep their flags but are masked from the interrupt
        assign timer_irq[i] = (|timer_status[i*STATUS_W +: STATUS_W]) & reg_timer_enable[i];
    end

    assign nint = ~|timer_irq;

endmodule

// File: tb/tb_wts_timer_array.sv
// tb_wts_timer_array: directed self-checking bench for wts_timer_array
// with default parameters (2 timers, ADDR_W=2, CNT_W=4).
module tb_wts_timer_array;

    localparam int NT = 2;
    localparam int AW = 2;
    localparam int CW = 4;
    localparam int SW = 4;
`ifdef WTS_TIMER_OVERRUN_EN
    localparam logic OV = 1'b1;
`else
    localparam logic OV = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [NT-1:0]     timer_trigger;
    logic [NT*AW-1:0]  timer_address;
    logic [NT-1:0]     reg_timer_enable;
    logic [NT-1:0]     reg_timer_oneshot;
    logic [NT-1:0]     reg_timer_clear;
    logic [NT*SW-1:0]  timer_status;
    logic [NT*CW-1:0]  timer_count;
    logic [NT-1:0]     timer_overrun;
    logic              nint;

    int n_checks = 0;
    int n_errors = 0;

    wts_timer_array #(.NUM_TIMERS(NT), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .timer_trigger     (timer_trigger),
        .timer_address     (timer_address),
        .reg_timer_enable  (reg_timer_enable),
        .reg_timer_oneshot (reg_timer_oneshot),
        .reg_timer_clear   (reg_timer_clear),
        .timer_status      (timer_status),
        .timer_count       (timer_count),
        .timer_overrun     (timer_overrun),
        .nint              (nint)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive a trigger pulse on one timer for one cycle
    task automatic fire(input int t, input logic [AW-1:0] a, input logic clr);
        timer_trigger[t]           = 1'b1;
        timer_address[t*AW +: AW]  = a;
        reg_timer_clear[t]         = clr;
        step();
        timer_trigger[t]   = 1'b0;
        reg_timer_clear[t] = 1'b0;
    endtask

    task automatic pulse_clear(input int t);
        reg_timer_clear[t] = 1'b1;
        step();
        reg_timer_clear[t] = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        timer_trigger     = '0;
        timer_address     = '0;
        reg_timer_enable  = '0;
        reg_timer_oneshot = '0;
        reg_timer_clear   = '0;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_status", 32'(timer_status), 32'h0);
        check("rst_count", 32'(timer_count), 32'h0);
        check("rst_overrun", 32'(timer_overrun), 32'h0);
        check("rst_nint", 32'(nint), 32'h1);

        // basic event on timer 0 at address 2
        reg_timer_enable[0] = 1'b1;
        step();
        step();
        fire(0, 2'd2, 1'b0);
        check("t1_status0", 32'(timer_status[3:0]), 32'h4);
        check("t1_count0", 32'(timer_count[3:0]), 32'h1);
        check("t1_nint", 32'(nint), 32'h0);
        check("t1_status1", 32'(timer_status[7:4]), 32'h0);

        // one-shot lock: second event ignored
        pulse_clear(0);
        check("t2_clr_nint", 32'(nint), 32'h1);
        reg_timer_oneshot[0] = 1'b1;
        fire(0, 2'd1, 1'b0);
        fire(0, 2'd3, 1'b0);
        check("t2_lock_status", 32'(timer_status[3:0]), 32'h2);
        check("t2_lock_count", 32'(timer_count[3:0]), 32'h1);
        check("t2_lock_ovr", 32'(timer_overrun[0]), 32'(OV));
        pulse_clear(0);
        check("t2_clear_status", 32'(timer_status[3:0]), 32'h0);
        check("t2_clear_nint", 32'(nint), 32'h1);
        check("t2_clear_ovr", 32'(timer_overrun[0]), 32'h0);
        fire(0, 2'd3, 1'b0);
        check("t2_rearm_status", 32'(timer_status[3:0]), 32'h8);
        reg_timer_oneshot[0] = 1'b0;
        pulse_clear(0);

        // saturation on timer 1
        reg_timer_enable[1] = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            fire(1, 2'(i % 4), 1'b0);
            if (i == 14) check("t3_count_15", 32'(timer_count[7:4]), 32'd15);
        end
        check("t3_count_sat", 32'(timer_count[7:4]), 32'd15);
        check("t3_status1", 32'(timer_status[7:4]), 32'hf);
        check("t3_ovr1", 32'(timer_overrun[1]), 32'(OV));
        check("t3_nint", 32'(nint), 32'h0);
        pulse_clear(1);
        check("t3_clear_count", 32'(timer_count[7:4]), 32'd0);

        // clear + trigger in the same cycle
        for (int i = 0; i < 5; i++) fire(0, 2'd2, 1'b0);
        check("t4_count5", 32'(timer_count[3:0]), 32'd5);
        check("t4_ovr_rep", 32'(timer_overrun[0]), 32'(OV));
        fire(0, 2'd0, 1'b1);
        check("t4_status", 32'(timer_status[3:0]), 32'h1);
        check("t4_count", 32'(timer_count[3:0]), 32'd1);
        check("t4_ovr_clr", 32'(timer_overrun[0]), 32'h0);

        // disable masks nint but keeps state; re-enable ignores first trigger
        check("t5_nint_pend", 32'(nint), 32'h0);
        reg_timer_enable[0] = 1'b0;
        #1;
        check("t5_nint_masked", 32'(nint), 32'h1);
        step();
        check("t5_status_kept", 32'(timer_status[3:0]), 32'h1);
        check("t5_count_kept", 32'(timer_count[3:0]), 32'd1);
        reg_timer_enable[0] = 1'b1;
        fire(0, 2'd3, 1'b0);
        check("t5_first_ign_st", 32'(timer_status[3:0]), 32'h1);
        check("t5_first_ign_cnt", 32'(timer_count[3:0]), 32'd1);
        check("t5_nint_reen", 32'(nint), 32'h0);
        fire(0, 2'd3, 1'b0);
        check("t5_status_next", 32'(timer_status[3:0]), 32'h9);
        check("t5_count_next", 32'(timer_count[3:0]), 32'd2);

        // simultaneous triggers on both timers
        timer_trigger = 2'b11;
        timer_address = {2'd1, 2'd0};
        step();
        timer_trigger = '0;
        check("t6_status", 32'(timer_status), 32'h29);
        check("t6_count", 32'(timer_count), 32'h13);

        // reset mid-operation
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7_status", 32'(timer_status), 32'h0);
        check("t7_count", 32'(timer_count), 32'h0);
        check("t7_nint", 32'(nint), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
